// File: rtl/ctx_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ctx_mem_arbiter
//
// Shares one memory data port between the CPU core and the RTOS context unit.
// Context writes are absorbed by a small FIFO and drained into memory whenever
// the port is otherwise idle. Context reads are issued directly. The core has
// priority over both, except when a buffered write has waited STARVE_LIMIT
// cycles: then the write is forced out and the core is held off for that
// single cycle.
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   core_req_i / core_hold_o      core wants the port / core must stall now
//   wr_valid_i, wr_ready_o,
//   wr_addr_i, wr_data_i          context-write request into the buffer
//   rd_valid_i, rd_ready_o,
//   rd_addr_i                     context-read request
//   rd_resp_valid_o,
//   rd_resp_data_o                context-read response back to the unit
//   mem_wr_en_o, mem_wr_addr_o,
//   mem_wr_data_o                 memory write port (shows buffer head)
//   mem_rd_rq_valid_o,
//   mem_rd_rq_addr_o              memory read-request port
//   mem_rd_resp_valid_i,
//   mem_rd_data_i                 memory read-response port
//   wbuf_empty_o                  registered "all context writes done"
//   rd_outst_o                    number of reads awaiting a response
//   protocol_err_o                sticky: response seen with nothing pending
// ---------------------------------------------------------------------------
module ctx_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WBUF_DEPTH   = 4,
    parameter int MAX_RD_OUTST = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,

    input  logic                              core_req_i,
    output logic                              core_hold_o,

    input  logic                              wr_valid_i,
    output logic                              wr_ready_o,
    input  logic [ADDR_W-1:0]                 wr_addr_i,
    input  logic [DATA_W-1:0]                 wr_data_i,

    input  logic                              rd_valid_i,
    output logic                              rd_ready_o,
    input  logic [ADDR_W-1:0]                 rd_addr_i,
    output logic                              rd_resp_valid_o,
    output logic [DATA_W-1:0]                 rd_resp_data_o,

    output logic                              mem_wr_en_o,
    output logic [ADDR_W-1:0]                 mem_wr_addr_o,
    output logic [DATA_W-1:0]                 mem_wr_data_o,
    output logic                              mem_rd_rq_valid_o,
    output logic [ADDR_W-1:0]                 mem_rd_rq_addr_o,
    input  logic                              mem_rd_resp_valid_i,
    input  logic [DATA_W-1:0]                 mem_rd_data_i,

    output logic                              wbuf_empty_o,
    output logic [$clog2(MAX_RD_OUTST+1)-1:0] rd_outst_o,
    output logic                              protocol_err_o
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = $clog2(WBUF_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int OUT_W = $clog2(MAX_RD_OUTST + 1);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(WBUF_DEPTH);
    localparam logic [STV_W-1:0] STARVE_C  = STV_W'(STARVE_LIMIT);
    localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_RD_OUTST);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]     addr_mem_reg [WBUF_DEPTH];
    logic [DATA_W-1:0]     data_mem_reg [WBUF_DEPTH];

    logic [WBUF_DEPTH-1:0] entry_valid_reg, entry_valid_next;
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [STV_W-1:0]      starve_reg, starve_next;
    logic [OUT_W-1:0]      outst_reg, outst_next;
    logic                  perr_reg, perr_next;
    logic                  wbuf_empty_reg, wbuf_empty_next;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  force_wr;
    logic                  hazard;
    logic                  rd_accept;
    logic                  resp_ok;
    logic                  push;
    logic                  pop;
    logic [WBUF_DEPTH-1:0] addr_match;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == DEPTH_C);

    // A buffered write that has waited the full limit wins over everything.
    assign force_wr   = (starve_reg == STARVE_C) & ~fifo_empty;

    // A read must not overtake a buffered write to the same address, so any
    // address match against a live entry blocks the read until it drains.
    // The incoming write of this same cycle is deliberately not compared: it
    // lands in the FIFO after the read has already been issued.
    for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_entry
        assign addr_match[gi] = entry_valid_reg[gi] &
                                (addr_mem_reg[gi] == rd_addr_i);

        assign entry_valid_next[gi] =
            (push & (wr_ptr_reg == PTR_W'(gi))) |
            (entry_valid_reg[gi] & ~(pop & (rd_ptr_reg == PTR_W'(gi))));
    end

    assign hazard = |addr_match;

    // rst_ni is folded in so no read strobe escapes while reset is held.
    assign rd_ready_o = rst_ni & ~force_wr & ~core_req_i &
                        (outst_reg < MAX_OUT_C) & ~hazard;
    assign rd_accept  = rd_valid_i & rd_ready_o;

    // Pop priority: forced write, else idle port (no core, no read issued).
    // The pop only ever sees entries that were already registered, so a word
    // pushed into an empty buffer goes out no earlier than the next cycle.
    assign pop  = force_wr | (~core_req_i & ~rd_accept & ~fifo_empty);
    assign push = wr_valid_i & ~fifo_full;

    // Responses with nothing outstanding are swallowed and flagged.
    assign resp_ok = mem_rd_resp_valid_i & (outst_reg != '0);

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        starve_next     = starve_reg;
        outst_next      = outst_reg;
        perr_next       = perr_reg;
        wbuf_empty_next = wbuf_empty_reg;

        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        // Wait counter only runs while a write sits un-served; any pop
        // restarts the count for the new head.
        if (pop || fifo_empty) begin
            starve_next = '0;
        end else if (starve_reg != STARVE_C) begin
            starve_next = starve_reg + STV_W'(1);
        end

        case ({rd_accept, resp_ok})
            2'b10:   outst_next = outst_reg + OUT_W'(1);
            2'b01:   outst_next = outst_reg - OUT_W'(1);
            default: outst_next = outst_reg;
        endcase

        if (mem_rd_resp_valid_i && (outst_reg == '0)) begin
            perr_next = 1'b1;
        end

        wbuf_empty_next = (count_next == '0);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_valid_reg <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            starve_reg      <= '0;
            outst_reg       <= '0;
            perr_reg        <= 1'b0;
            wbuf_empty_reg  <= 1'b1;
        end else begin
            entry_valid_reg <= entry_valid_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            starve_reg      <= starve_next;
            outst_reg       <= outst_next;
            perr_reg        <= perr_next;
            wbuf_empty_reg  <= wbuf_empty_next;
        end
    end

    // Payload storage needs no reset: entry_valid_reg and the pointers
    // decide what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_reg[wr_ptr_reg] <= wr_addr_i;
            data_mem_reg[wr_ptr_reg] <= wr_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_ready_o        = ~fifo_full;
    assign core_hold_o       = force_wr;

    assign mem_wr_en_o       = pop;
    assign mem_wr_addr_o     = addr_mem_reg[rd_ptr_reg];
    assign mem_wr_data_o     = data_mem_reg[rd_ptr_reg];

    assign mem_rd_rq_valid_o = rd_accept;
    assign mem_rd_rq_addr_o  = rd_addr_i;

    assign rd_resp_valid_o   = resp_ok;
    assign rd_resp_data_o    = mem_rd_data_i;

    assign wbuf_empty_o      = wbuf_empty_reg;
    assign rd_outst_o        = outst_reg;
    assign protocol_err_o    = perr_reg;

endmodule

// File: tb/tb_ctx_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ctx_mem_arbiter
//
// Directed scenario tasks followed by a long randomized run compared
// against a queue-based reference model of the arbitration rules.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the falling edge.
// ---------------------------------------------------------------------------
module tb_ctx_mem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int WBUF_DEPTH   = 4;
    localparam int MAX_RD_OUTST = 2;
    localparam int STARVE_LIMIT = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic              core_req_i;
    logic              core_hold_o;
    logic              wr_valid_i;
    logic              wr_ready_o;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              rd_valid_i;
    logic              rd_ready_o;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_resp_valid_o;
    logic [DATA_W-1:0] rd_resp_data_o;
    logic              mem_wr_en_o;
    logic [ADDR_W-1:0] mem_wr_addr_o;
    logic [DATA_W-1:0] mem_wr_data_o;
    logic              mem_rd_rq_valid_o;
    logic [ADDR_W-1:0] mem_rd_rq_addr_o;
    logic              mem_rd_resp_valid_i;
    logic [DATA_W-1:0] mem_rd_data_i;
    logic              wbuf_empty_o;
    logic [1:0]        rd_outst_o;
    logic              protocol_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ctx_mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WBUF_DEPTH  (WBUF_DEPTH),
        .MAX_RD_OUTST(MAX_RD_OUTST),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .core_req_i         (core_req_i),
        .core_hold_o        (core_hold_o),
        .wr_valid_i         (wr_valid_i),
        .wr_ready_o         (wr_ready_o),
        .wr_addr_i          (wr_addr_i),
        .wr_data_i          (wr_data_i),
        .rd_valid_i         (rd_valid_i),
        .rd_ready_o         (rd_ready_o),
        .rd_addr_i          (rd_addr_i),
        .rd_resp_valid_o    (rd_resp_valid_o),
        .rd_resp_data_o     (rd_resp_data_o),
        .mem_wr_en_o        (mem_wr_en_o),
        .mem_wr_addr_o      (mem_wr_addr_o),
        .mem_wr_data_o      (mem_wr_data_o),
        .mem_rd_rq_valid_o  (mem_rd_rq_valid_o),
        .mem_rd_rq_addr_o   (mem_rd_rq_addr_o),
        .mem_rd_resp_valid_i(mem_rd_resp_valid_i),
        .mem_rd_data_i      (mem_rd_data_i),
        .wbuf_empty_o       (wbuf_empty_o),
        .rd_outst_o         (rd_outst_o),
        .protocol_err_o     (protocol_err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        core_req_i          = 1'b0;
        wr_valid_i          = 1'b0;
        wr_addr_i           = '0;
        wr_data_i           = '0;
        rd_valid_i          = 1'b0;
        rd_addr_i           = '0;
        mem_rd_resp_valid_i = 1'b0;
        mem_rd_data_i       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        #2 rst_ni = 1'b0;
        tick();
        // Active requests while reset is held must not produce strobes.
        wr_valid_i          = 1'b1;
        rd_valid_i          = 1'b1;
        mem_rd_resp_valid_i = 1'b1;
        #4;
        n_checks++; if (wbuf_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_wbuf_empty: got %b want 1", wbuf_empty_o); end
        n_checks++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready_o); end
        n_checks++; if (mem_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr_en: got %b want 0", mem_wr_en_o); end
        n_checks++; if (mem_rd_rq_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd_rq: got %b want 0", mem_rd_rq_valid_o); end
        n_checks++; if (core_hold_o !== 1'b0) begin n_fail++; $display("FAIL reset_core_hold: got %b want 0", core_hold_o); end
        n_checks++; if (rd_resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_resp_valid: got %b want 0", rd_resp_valid_o); end
        n_checks++; if (rd_outst_o !== 2'd0) begin n_fail++; $display("FAIL reset_outst: got %0d want 0", rd_outst_o); end
        n_checks++; if (protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", protocol_err_o); end
        tick();
        idle_inputs();
        rst_ni = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_in_order();
        logic [ADDR_W-1:0] a [4];
        logic [DATA_W-1:0] d [4];
        logic              exp_en;
        logic              exp_empty;
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'h0000_1000 + 32'(i * 16);
            d[i] = $urandom;
        end
        for (int i = 0; i < 6; i++) begin
            wr_valid_i = (i < 4);
            if (i < 4) begin
                wr_addr_i = a[i];
                wr_data_i = d[i];
            end
            #4;
            exp_en    = (i >= 1) && (i <= 4);
            exp_empty = (i == 0) || (i == 5);
            n_checks++; if (mem_wr_en_o !== exp_en) begin n_fail++; $display("FAIL in_order_en cyc%0d: got %b want %b", i, mem_wr_en_o, exp_en); end
            if (exp_en) begin
                n_checks++;
                if (mem_wr_addr_o !== a[i-1] || mem_wr_data_o !== d[i-1]) begin
                    n_fail++;
                    $display("FAIL in_order_word cyc%0d: got %h/%h want %h/%h", i, mem_wr_addr_o, mem_wr_data_o, a[i-1], d[i-1]);
                end
            end
            n_checks++; if (wbuf_empty_o !== exp_empty) begin n_fail++; $display("FAIL in_order_empty cyc%0d: got %b want %b", i, wbuf_empty_o, exp_empty); end
            tick();
        end
        idle_inputs();
        $display("test_in_order done");
    endtask

    // ------------------------------------------------------------------
    // Two forced writes 10 cycles apart: the second needs a full fresh
    // wait, which shows the wait counter restarted after the first.
    task automatic test_starve();
        logic exp_force;
        core_req_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_valid_i = (i == 0) || (i == 10);
            wr_addr_i  = 32'h0000_2000 + 32'(i);
            wr_data_i  = 32'hCAFE_0000 + 32'(i);
            #4;
            exp_force = (i == 9) || (i == 19);
            n_checks++; if (mem_wr_en_o !== exp_force) begin n_fail++; $display("FAIL starve_wr_en cyc%0d: got %b want %b", i, mem_wr_en_o, exp_force); end
            n_checks++; if (core_hold_o !== exp_force) begin n_fail++; $display("FAIL starve_hold cyc%0d: got %b want %b", i, core_hold_o, exp_force); end
            if (exp_force) begin
                n_checks++;
                if (mem_wr_addr_o !== 32'h0000_2000 + 32'(i - 9)) begin
                    n_fail++;
                    $display("FAIL starve_addr cyc%0d: got %h want %h", i, mem_wr_addr_o, 32'h0000_2000 + 32'(i - 9));
                end
            end
            tick();
        end
        idle_inputs();
        $display("test_starve done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        logic [ADDR_W-1:0] b [5];
        logic              exp_ready;
        logic              exp_en;
        for (int i = 0; i < 5; i++) b[i] = 32'h0000_3000 + 32'(i * 4);
        for (int i = 0; i < 10; i++) begin
            core_req_i = (i < 5);
            wr_valid_i = (i < 5);
            if (i < 5) begin
                wr_addr_i = b[i];
                wr_data_i = 32'(i);
            end
            #4;
            exp_ready = !((i == 4) || (i == 5));
            exp_en    = (i >= 5) && (i <= 8);
            n_checks++; if (wr_ready_o !== exp_ready) begin n_fail++; $display("FAIL full_wr_ready cyc%0d: got %b want %b", i, wr_ready_o, exp_ready); end
            n_checks++; if (mem_wr_en_o !== exp_en) begin n_fail++; $display("FAIL full_wr_en cyc%0d: got %b want %b", i, mem_wr_en_o, exp_en); end
            if (exp_en) begin
                n_checks++; if (mem_wr_addr_o !== b[i-5]) begin n_fail++; $display("FAIL full_order cyc%0d: got %h want %h", i, mem_wr_addr_o, b[i-5]); end
            end
            tick();
        end
        #4;
        n_checks++; if (wbuf_empty_o !== 1'b1) begin n_fail++; $display("FAIL full_drained: got %b want 1", wbuf_empty_o); end
        tick();
        idle_inputs();
        $display("test_full done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_hazard();
        // cycle 0: buffer a write to 0x100 while the core owns the port
        core_req_i = 1'b1;
        wr_valid_i = 1'b1; wr_addr_i = 32'h100; wr_data_i = 32'hAAAA_0001;
        tick();
        // cycle 1: read of the same address, core still busy
        wr_valid_i = 1'b0;
        rd_valid_i = 1'b1; rd_addr_i = 32'h100;
        #4;
        n_checks++; if (rd_ready_o !== 1'b0) begin n_fail++; $display("FAIL hazard_c1_ready: got %b want 0", rd_ready_o); end
        tick();
        // cycle 2: core idle; only the address hazard blocks the read
        core_req_i = 1'b0;
        #4;
        n_checks++; if (rd_ready_o !== 1'b0) begin n_fail++; $display("FAIL hazard_c2_ready: got %b want 0", rd_ready_o); end
        n_checks++; if (mem_wr_en_o !== 1'b1 || mem_wr_addr_o !== 32'h100) begin n_fail++; $display("FAIL hazard_c2_write: got en=%b addr=%h want en=1 addr=100", mem_wr_en_o, mem_wr_addr_o); end
        tick();
        // cycle 3: read accepted; a same-address write pushed now must follow it
        wr_valid_i = 1'b1; wr_addr_i = 32'h100; wr_data_i = 32'hBBBB_0002;
        #4;
        n_checks++; if (mem_rd_rq_valid_o !== 1'b1 || mem_rd_rq_addr_o !== 32'h100) begin n_fail++; $display("FAIL hazard_c3_read: got v=%b addr=%h want v=1 addr=100", mem_rd_rq_valid_o, mem_rd_rq_addr_o); end
        n_checks++; if (mem_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL hazard_c3_wr_en: got %b want 0", mem_wr_en_o); end
        tick();
        // cycle 4: write drains, response returns
        wr_valid_i = 1'b0; rd_valid_i = 1'b0;
        mem_rd_resp_valid_i = 1'b1; mem_rd_data_i = 32'h1234_ABCD;
        #4;
        n_checks++; if (mem_wr_en_o !== 1'b1 || mem_wr_data_o !== 32'hBBBB_0002) begin n_fail++; $display("FAIL hazard_c4_write: got en=%b data=%h want en=1 data=bbbb0002", mem_wr_en_o, mem_wr_data_o); end
        n_checks++; if (rd_resp_valid_o !== 1'b1 || rd_resp_data_o !== 32'h1234_ABCD) begin n_fail++; $display("FAIL hazard_c4_resp: got v=%b d=%h want v=1 d=1234abcd", rd_resp_valid_o, rd_resp_data_o); end
        n_checks++; if (rd_outst_o !== 2'd1) begin n_fail++; $display("FAIL hazard_c4_outst: got %0d want 1", rd_outst_o); end
        tick();
        idle_inputs();
        #4;
        n_checks++; if (rd_outst_o !== 2'd0) begin n_fail++; $display("FAIL hazard_c5_outst: got %0d want 0", rd_outst_o); end
        n_checks++; if (wbuf_empty_o !== 1'b1) begin n_fail++; $display("FAIL hazard_c5_empty: got %b want 1", wbuf_empty_o); end
        tick();
        $display("test_hazard done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_outst();
        rd_valid_i = 1'b1; rd_addr_i = 32'h200;
        #4;
        n_checks++; if (rd_ready_o !== 1'b1 || mem_rd_rq_valid_o !== 1'b1) begin n_fail++; $display("FAIL outst_c0: got rdy=%b rq=%b want 1/1", rd_ready_o, mem_rd_rq_valid_o); end
        tick();
        rd_addr_i = 32'h204;
        #4;
        n_checks++; if (rd_outst_o !== 2'd1 || rd_ready_o !== 1'b1) begin n_fail++; $display("FAIL outst_c1: got outst=%0d rdy=%b want 1/1", rd_outst_o, rd_ready_o); end
        tick();
        // limit reached: new read refused even while a response arrives
        rd_addr_i = 32'h208;
        mem_rd_resp_valid_i = 1'b1; mem_rd_data_i = 32'h0000_0AA0;
        #4;
        n_checks++; if (rd_outst_o !== 2'd2) begin n_fail++; $display("FAIL outst_c2_count: got %0d want 2", rd_outst_o); end
        n_checks++; if (rd_ready_o !== 1'b0 || mem_rd_rq_valid_o !== 1'b0) begin n_fail++; $display("FAIL outst_c2_block: got rdy=%b rq=%b want 0/0", rd_ready_o, mem_rd_rq_valid_o); end
        n_checks++; if (rd_resp_valid_o !== 1'b1 || rd_resp_data_o !== 32'h0000_0AA0) begin n_fail++; $display("FAIL outst_c2_resp: got v=%b d=%h", rd_resp_valid_o, rd_resp_data_o); end
        tick();
        // response plus accepted read in the same cycle
        mem_rd_data_i = 32'h0000_0BB1;
        #4;
        n_checks++; if (rd_outst_o !== 2'd1 || mem_rd_rq_valid_o !== 1'b1) begin n_fail++; $display("FAIL outst_c3: got outst=%0d rq=%b want 1/1", rd_outst_o, mem_rd_rq_valid_o); end
        tick();
        rd_valid_i = 1'b0; mem_rd_data_i = 32'h0000_0CC2;
        #4;
        n_checks++; if (rd_outst_o !== 2'd1) begin n_fail++; $display("FAIL outst_c4_unchanged: got %0d want 1", rd_outst_o); end
        tick();
        idle_inputs();
        #4;
        n_checks++; if (rd_outst_o !== 2'd0 || protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL outst_c5: got outst=%0d perr=%b want 0/0", rd_outst_o, protocol_err_o); end
        tick();
        $display("test_outst done");
    endtask

    // ------------------------------------------------------------------
    task automatic test_protocol_err();
        mem_rd_resp_valid_i = 1'b1; mem_rd_data_i = 32'hDEAD_BEEF;
        #4;
        n_checks++; if (rd_resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL perr_dropped: got %b want 0", rd_resp_valid_o); end
        tick();
        mem_rd_resp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            n_checks++; if (protocol_err_o !== 1'b1 || rd_outst_o !== 2'd0) begin n_fail++; $display("FAIL perr_sticky cyc%0d: got perr=%b outst=%0d want 1/0", i, protocol_err_o, rd_outst_o); end
            tick();
        end
        // mid-operation reset: one read in flight, two writes buffered
        rd_valid_i = 1'b1; rd_addr_i = 32'h300;
        tick();
        rd_valid_i = 1'b0; core_req_i = 1'b1;
        wr_valid_i = 1'b1; wr_addr_i = 32'h400; wr_data_i = 32'h1;
        tick();
        wr_addr_i = 32'h404; wr_data_i = 32'h2;
        tick();
        idle_inputs();
        rst_ni = 1'b0;
        #1;
        n_checks++; if (wbuf_empty_o !== 1'b1 || wr_ready_o !== 1'b1) begin n_fail++; $display("FAIL midreset_wbuf: got empty=%b rdy=%b want 1/1", wbuf_empty_o, wr_ready_o); end
        n_checks++; if (rd_outst_o !== 2'd0 || protocol_err_o !== 1'b0) begin n_fail++; $display("FAIL midreset_track: got outst=%0d perr=%b want 0/0", rd_outst_o, protocol_err_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        // late response for the discarded read
        mem_rd_resp_valid_i = 1'b1; mem_rd_data_i = 32'h5555_AAAA;
        #4;
        n_checks++; if (rd_resp_valid_o !== 1'b0 || mem_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL postreset_resp: got v=%b wr_en=%b want 0/0", rd_resp_valid_o, mem_wr_en_o); end
        tick();
        mem_rd_resp_valid_i = 1'b0;
        #4;
        n_checks++; if (protocol_err_o !== 1'b1) begin n_fail++; $display("FAIL postreset_perr: got %b want 1", protocol_err_o); end
        tick();
        do_reset();
        $display("test_protocol_err done");
    endtask

    // ------------------------------------------------------------------
    // Reference model: the buffer is a queue of {addr,data}; the wait count,
    // outstanding reads and error flag are plain integers.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    task automatic test_random();
        wr_t q[$];
        int  starve = 0;
        int  outst  = 0;
        bit  perr   = 0;
        bit  empty, force_w, hazard, exp_rdy, acc, pop, push, resp_ok, burst;
        int  n_force = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            burst      = ((cyc / 50) % 3) == 1;
            core_req_i = burst ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            wr_valid_i = $urandom_range(0, 1) == 1;
            wr_addr_i  = 32'($urandom_range(0, 7) * 4);
            wr_data_i  = $urandom;
            rd_valid_i = $urandom_range(0, 1) == 1;
            rd_addr_i  = 32'($urandom_range(0, 7) * 4);
            mem_rd_resp_valid_i = (outst > 0) && ($urandom_range(0, 2) == 0);
            mem_rd_data_i = $urandom;
            #4;
            empty   = (q.size() == 0);
            force_w = (starve == STARVE_LIMIT) && !empty;
            hazard  = 0;
            foreach (q[k]) if (q[k].a == rd_addr_i) hazard = 1;
            exp_rdy = !force_w && !core_req_i && (outst < MAX_RD_OUTST) && !hazard;
            acc     = rd_valid_i && exp_rdy;
            pop     = force_w || (!core_req_i && !acc && !empty);
            push    = wr_valid_i && (q.size() < WBUF_DEPTH);
            resp_ok = mem_rd_resp_valid_i && (outst > 0);

            n_checks++; if (wr_ready_o !== (q.size() < WBUF_DEPTH)) begin n_fail++; $display("FAIL rnd_wr_ready cyc%0d: got %b want %b", cyc, wr_ready_o, q.size() < WBUF_DEPTH); end
            n_checks++; if (rd_ready_o !== exp_rdy) begin n_fail++; $display("FAIL rnd_rd_ready cyc%0d: got %b want %b", cyc, rd_ready_o, exp_rdy); end
            n_checks++; if (mem_rd_rq_valid_o !== acc) begin n_fail++; $display("FAIL rnd_rd_rq cyc%0d: got %b want %b", cyc, mem_rd_rq_valid_o, acc); end
            n_checks++; if (mem_wr_en_o !== pop) begin n_fail++; $display("FAIL rnd_wr_en cyc%0d: got %b want %b", cyc, mem_wr_en_o, pop); end
            if (pop) begin
                n_checks++;
                if (mem_wr_addr_o !== q[0].a || mem_wr_data_o !== q[0].d) begin
                    n_fail++;
                    $display("FAIL rnd_wr_word cyc%0d: got %h/%h want %h/%h", cyc, mem_wr_addr_o, mem_wr_data_o, q[0].a, q[0].d);
                end
            end
            n_checks++; if (core_hold_o !== force_w) begin n_fail++; $display("FAIL rnd_hold cyc%0d: got %b want %b", cyc, core_hold_o, force_w); end
            n_checks++; if (wbuf_empty_o !== empty) begin n_fail++; $display("FAIL rnd_wbuf_empty cyc%0d: got %b want %b", cyc, wbuf_empty_o, empty); end
            n_checks++; if (rd_outst_o !== 2'(outst)) begin n_fail++; $display("FAIL rnd_outst cyc%0d: got %0d want %0d", cyc, rd_outst_o, outst); end
            n_checks++; if (rd_resp_valid_o !== resp_ok) begin n_fail++; $display("FAIL rnd_resp_valid cyc%0d: got %b want %b", cyc, rd_resp_valid_o, resp_ok); end
            n_checks++; if (protocol_err_o !== perr) begin n_fail++; $display("FAIL rnd_perr cyc%0d: got %b want %b", cyc, protocol_err_o, perr); end

            tick();
            if (force_w) n_force++;
            if (pop) void'(q.pop_front());
            if (push) q.push_back({wr_addr_i, wr_data_i});
            if (pop || empty) starve = 0;
            else if (starve < STARVE_LIMIT) starve++;
            outst = outst + (acc ? 1 : 0) - (resp_ok ? 1 : 0);
        end
        idle_inputs();
        $display("test_random done: %0d forced writes seen", n_force);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_in_order();
        test_starve();
        test_full();
        test_hazard();
        test_outst();
        test_protocol_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
